// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
// Shared types and constants for the iterative restoring divider.
//   WIDTH      : operand width in bits
//   ITERATIONS : number of radix-2 steps per division (one per quotient bit)
//   CNT_W      : width of the iteration counter (must hold ITERATIONS itself)
//   state_t    : controller states
//   word_t     : operand / result word
//   rem_t      : remainder accumulator, one bit wider than an operand so the
//                compare against the divisor can never overflow
//   count_t    : iteration counter
// -----------------------------------------------------------------------------
package divider_pkg;

    parameter int WIDTH      = 32;
    localparam int ITERATIONS = WIDTH;
    localparam int CNT_W      = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [WIDTH:0]   rem_t;
    typedef logic [CNT_W-1:0] count_t;

endpackage

// File: rtl/divider_iterative_if.sv
// -----------------------------------------------------------------------------
// divider_iterative_if
// Operand and result handshakes of the iterative divider.
//   in_valid  / in_ready  : operand pair a, b is transferred on a rising edge
//                           where both are 1.
//   out_valid / out_ready : result q, r is transferred on a rising edge where
//                           both are 1.
// Handshake rule (both channels): a transfer happens on exactly those edges
// where valid and ready are both 1; the producer holds its data while valid is
// 1, and ready/valid of the divider are decoded from registered state only, so
// neither depends combinationally on the other side's signals.
// Modports:
//   master : the client (drives operands, consumes results)
//   slave  : the divider
// -----------------------------------------------------------------------------
interface divider_iterative_if;
    import divider_pkg::*;

    logic  in_valid;
    logic  in_ready;
    word_t a;
    word_t b;
    logic  out_valid;
    logic  out_ready;
    word_t q;
    word_t r;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, q, r
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, q, r
    );

endinterface

// File: rtl/divider_iterative_step.sv
// -----------------------------------------------------------------------------
// divider_step
// One combinational radix-2 restoring division iteration.
//   i_rem     : current remainder accumulator
//   i_divisor : divisor
//   i_bit     : next dividend bit (MSB first)
//   o_rem     : remainder after shift and conditional subtract
//   o_q_bit   : quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module divider_step
    import divider_pkg::*;
(
    input  rem_t  i_rem,
    input  word_t i_divisor,
    input  logic  i_bit,
    output rem_t  o_rem,
    output logic  o_q_bit
);

    rem_t w_shifted;
    rem_t w_divisor_ext;
    logic w_ge;

    assign w_shifted     = {i_rem[WIDTH-1:0], i_bit};
    assign w_divisor_ext = {1'b0, i_divisor};

    // A set top bit in the incoming accumulator would shift out of w_shifted;
    // the true shifted value is then certainly >= the divisor. In normal
    // operation that bit stays 0 because the remainder is always < divisor.
    assign w_ge    = i_rem[WIDTH] | (w_shifted >= w_divisor_ext);
    assign o_rem   = w_ge ? (w_shifted - w_divisor_ext) : w_shifted;
    assign o_q_bit = w_ge;

endmodule

// File: rtl/divider_iterative.sv
// -----------------------------------------------------------------------------
// divider_iterative
// Unsigned 32-bit iterative restoring divider, one quotient bit per clock.
// Fixed latency: operands accepted on edge E0, steps on E1..E32, result valid
// after E32 and held until consumed. Division by zero yields q = all ones,
// r = a (the natural restoring result).
//   clk         : clock, all state on rising edge
//   reset       : synchronous active-high reset
//   bus         : slave side of divider_iterative_if (operands in, result out)
//   o_dbg_state : current controller state, for observation only
// -----------------------------------------------------------------------------
module divider_iterative
    import divider_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    divider_iterative_if.slave    bus,
    output state_t                o_dbg_state
);

    state_t r_state;
    state_t w_next_state;

    word_t  r_dividend;
    word_t  r_divisor;
    word_t  r_quot;
    rem_t   r_rem;
    count_t r_count;

    rem_t   w_step_rem;
    logic   w_q_bit;
    logic   w_last_step;

    // Step 32 is the one taken while the counter still reads 31.
    assign w_last_step = (r_state == BUSY) && (r_count == count_t'(ITERATIONS - 1));

    // The dividend register shifts left each step, so its MSB is always the
    // next dividend bit to bring into the remainder.
    divider_step u_step (
        .i_rem     (r_rem),
        .i_divisor (r_divisor),
        .i_bit     (r_dividend[WIDTH-1]),
        .o_rem     (w_step_rem),
        .o_q_bit   (w_q_bit)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_next_state = BUSY;
                end
            end
            BUSY: begin
                if (w_last_step) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Datapath: operand capture and one restoring step per BUSY cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dividend <= '0;
            r_divisor  <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_count    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_dividend <= bus.a;
                        r_divisor  <= bus.b;
                        r_quot     <= '0;
                        r_rem      <= '0;
                        r_count    <= '0;
                    end
                end
                BUSY: begin
                    r_rem      <= w_step_rem;
                    r_dividend <= {r_dividend[WIDTH-2:0], 1'b0};
                    r_quot     <= {r_quot[WIDTH-2:0], w_q_bit};
                    // Saturate at ITERATIONS so the counter never wraps.
                    if (r_count != count_t'(ITERATIONS)) begin
                        r_count <= r_count + count_t'(1);
                    end
                end
                default: begin
                    // DONE holds q and r stable until consumed.
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.q         = r_quot;
    assign bus.r         = r_rem[WIDTH-1:0];
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_divider_iterative.sv
// -----------------------------------------------------------------------------
// tb_divider_iterative
// Directed and random checks of divider_iterative: reset state, fixed
// latency, divide by zero, extremes, back-pressure, busy-time input,
// out_ready on the DONE-entry edge, reset mid-division and a random sweep.
// Expected {q, r} pairs are queued when operands are driven and popped when
// the result appears.
// -----------------------------------------------------------------------------
module tb_divider_iterative;
    import divider_pkg::*;

    logic   clk;
    logic   reset;
    state_t o_dbg_state;

    divider_iterative_if bus ();

    divider_iterative dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    word_t       last_q;
    word_t       last_r;

    function automatic logic [63:0] model(input word_t a_in, input word_t b_in);
        if (b_in == '0) begin
            return {32'hFFFF_FFFF, a_in};
        end
        return {a_in / b_in, a_in % b_in};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Waits (bounded) for in_ready, offers one operand pair and returns
    // 1 time unit after the acceptance edge E0.
    task automatic send(input word_t a_in, input word_t b_in);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_before_send", 64'(bus.in_ready), 64'd1);
        bus.a        = a_in;
        bus.b        = b_in;
        bus.in_valid = 1'b1;
        exp_q.push_back(model(a_in, b_in));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Called right after send(). Counts edges until out_valid, checks the
    // result, optionally holds out_ready low, then consumes the result.
    task automatic collect(input int hold, input bit early_ready, input bit pulse_busy);
        int          lat;
        logic [63:0] exp_v;
        word_t       q0;
        word_t       r0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            if (early_ready && lat == 31) bus.out_ready = 1'b1;
            if (pulse_busy && lat == 5) begin
                bus.in_valid = 1'b1;
                bus.a        = $urandom;
                bus.b        = word_t'($urandom_range(1, 9));
            end
            if (pulse_busy && lat == 6) bus.in_valid = 1'b0;
            @(posedge clk); #1;
            lat++;
            if (lat == 8) chk("busy_in_ready", 64'(bus.in_ready), 64'd0);
        end
        chk("latency", 64'(lat), 64'd32);
        chk("done_state", 64'(o_dbg_state), 64'(DONE));
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
        end else begin
            exp_v = '1;
            chk("scoreboard_underflow", 64'(exp_q.size()), 64'd1);
        end
        q0 = bus.q;
        r0 = bus.r;
        chk("result_qr", {q0, r0}, exp_v);
        last_q = q0;
        last_r = r0;
        if (hold > 0) begin
            bus.out_ready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk("hold_qr", {bus.q, bus.r}, {q0, r0});
                chk("hold_valid_ready", 64'({bus.out_valid, bus.in_ready}), 64'b10);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("consumed_valid_ready", 64'({bus.out_valid, bus.in_ready}), 64'b01);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        word_t ra;
        word_t rb;

        bus.out_ready = 1'b0;
        // Reset with in_valid asserted: must not be accepted.
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.a        = 32'd50;
        bus.b        = 32'd5;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid_ready", 64'({bus.out_valid, bus.in_ready}), 64'b01);
        chk("reset_qr", {bus.q, bus.r}, 64'd0);
        chk("reset_state", 64'(o_dbg_state), 64'(IDLE));
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_reset", 64'(o_dbg_state), 64'(IDLE));

        // Basic case
        send(32'd100, 32'd7);
        collect(0, 1'b0, 1'b0);
        // Divide by zero
        send(32'h1234_5678, 32'd0);
        collect(0, 1'b0, 1'b0);
        // Extremes
        send(32'hFFFF_FFFF, 32'd1);
        collect(0, 1'b0, 1'b0);
        send(32'd5, 32'hFFFF_FFFF);
        collect(10, 1'b0, 1'b0);          // 10 cycles of back-pressure
        // New operands offered mid-division are ignored
        send(32'd100000, 32'd33);
        collect(0, 1'b0, 1'b1);
        // out_ready high on the DONE-entry edge, then held off
        send(32'd777, 32'd10);
        collect(3, 1'b1, 1'b0);

        // Reset at E10 of 1000/3; in_valid on the reset edge is ignored.
        send(32'd1000, 32'd3);
        void'(exp_q.pop_back());
        repeat (9) @(posedge clk);
        #1;
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.a        = 32'd77;
        bus.b        = 32'd5;
        @(posedge clk); #1;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        chk("midreset_valid_ready", 64'({bus.out_valid, bus.in_ready}), 64'b01);
        chk("midreset_qr", {bus.q, bus.r}, 64'd0);
        chk("midreset_state", 64'(o_dbg_state), 64'(IDLE));
        repeat (35) @(posedge clk);
        #1;
        chk("discarded_never_valid", 64'(bus.out_valid), 64'd0);
        send(32'd9, 32'd2);
        collect(0, 1'b0, 1'b0);

        // Random back-to-back sweep with out_ready high before results appear
        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom;
                1:       rb = word_t'($urandom_range(0, 15));
                2:       rb = $urandom >> $urandom_range(1, 31);
                default: rb = word_t'($urandom_range(1, 1000));
            endcase
            send(ra, rb);
            collect(0, 1'b1, 1'b0);
            if (rb != '0) begin
                chk("identity", 64'(last_q) * 64'(rb) + 64'(last_r), 64'(ra));
                chk("rem_below_divisor", 64'(last_r < rb), 64'd1);
            end
        end

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
